ord_tx: RTL and testbench

Order transmit block: the consuming end of the strategy engine's order interface. It accepts 128-bit order words over a valid/ready handshake and buffers them in a small FIFO. Each order is serialized into a 3-beat, 64-bit Avalon-ST packet for the outbound MAC/TCP-offload path: a sequence-numbered header, then payload high, then payload low. It also counts orders dropped because upstream asserted valid while this block was not ready.

---
 rtl/ord_tx.sv | 151 +++++++++++++++
 tb/tb_ord_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ord_tx.sv
// ord_tx: buffers 128-bit orders in a small FIFO and serializes each one
// into a 3-beat 64-bit Avalon-ST packet (header, payload high, payload low).
// Orders offered while the FIFO is full are lost and counted in drop_cnt.
module ord_tx #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [31:0] SEQ_INIT       = 32'h0000_0000,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ord_valid,
    input  logic [127:0]              ord_data,
    output logic                      ord_ready,
    output logic                      tx_valid,
    output logic [63:0]               tx_data,
    output logic                      tx_sop,
    output logic                      tx_eop,
    input  logic                      tx_ready,
    output logic [31:0]               seq_num,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    input  logic                      drop_clr
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        HDR = 2'd0,
        HI  = 2'd1,
        LO  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [127:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [127:0]    head;
    logic            empty;
    logic            wr_en;
    logic            pop;
    logic            drop;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    // ord_ready is a register, so a write is never helped by a same-cycle pop.
    assign wr_en = ord_valid && ord_ready;
    // tx_valid is always high in LO, so the LO handshake reduces to tx_ready.
    assign pop   = (state == LO) && tx_ready;
    assign drop  = ord_valid && !ord_ready;

    assign count_nxt = count + CW'(wr_en) - CW'(pop);

    // FIFO storage: written at the tail only, so the head stays stable mid-packet.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ord_data;
        end
    end

    // FIFO pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ord_ready <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count_nxt;
            ord_ready <= (count_nxt != CW'(FIFO_DEPTH));
        end
    end

    // Packet FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat selection and next state; outputs depend on state and FIFO head only.
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        case (state)
            HDR: begin
                if (!empty) begin
                    tx_valid = 1'b1;
                    tx_data  = {seq_num, 16'h0000, 16'd16};
                    tx_sop   = 1'b1;
                    if (tx_ready) begin
                        state_nxt = HI;
                    end
                end
            end
            HI: begin
                tx_valid = 1'b1;
                tx_data  = head[127:64];
                if (tx_ready) begin
                    state_nxt = LO;
                end
            end
            LO: begin
                tx_valid = 1'b1;
                tx_data  = head[63:0];
                tx_eop   = 1'b1;
                if (tx_ready) begin
                    state_nxt = HDR;
                end
            end
            default: begin
                state_nxt = HDR;
            end
        endcase
    end

    // Sequence number advances once per completed packet, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_num <= SEQ_INIT;
        end else if (pop) begin
            seq_num <= seq_num + 32'd1;
        end
    end

    // Saturating drop counter; a clear coincident with a drop leaves 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= drop ? DROP_CNT_WIDTH'(1) : '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ord_tx.sv
// tb_ord_tx: drives two ord_tx instances (SEQ_INIT 0 and FFFF_FFFF) with the
// same stimulus and compares every cycle against a queue-based packet model.
module tb_ord_tx;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] INIT0 = 32'h0000_0000;
    localparam logic [31:0] INIT1 = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         ord_valid;
    logic [127:0] ord_data;
    logic         tx_ready;
    logic         drop_clr;

    logic         ord_ready0, tx_valid0, tx_sop0, tx_eop0;
    logic [63:0]  tx_data0;
    logic [31:0]  seq_num0;
    logic [15:0]  drop_cnt0;
    logic         ord_ready1, tx_valid1, tx_sop1, tx_eop1;
    logic [63:0]  tx_data1;
    logic [31:0]  seq_num1;
    logic [15:0]  drop_cnt1;

    int unsigned  pass_cnt = 0;
    int unsigned  total_cnt = 0;
    int unsigned  hs_cnt = 0;

    // Reference model: pending orders, beat position of the head packet,
    // packets completed since reset, and the drop counter.
    logic [127:0] mq[$];
    int unsigned  m_beat;
    logic [31:0]  m_pkts;
    logic [15:0]  m_drop;

    always #5 clk = ~clk;

    ord_tx #(.FIFO_DEPTH(DEPTH), .SEQ_INIT(INIT0), .DROP_CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .ord_valid(ord_valid), .ord_data(ord_data),
        .ord_ready(ord_ready0), .tx_valid(tx_valid0), .tx_data(tx_data0),
        .tx_sop(tx_sop0), .tx_eop(tx_eop0), .tx_ready(tx_ready),
        .seq_num(seq_num0), .drop_cnt(drop_cnt0), .drop_clr(drop_clr)
    );

    ord_tx #(.FIFO_DEPTH(DEPTH), .SEQ_INIT(INIT1), .DROP_CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .ord_valid(ord_valid), .ord_data(ord_data),
        .ord_ready(ord_ready1), .tx_valid(tx_valid1), .tx_data(tx_data1),
        .tx_sop(tx_sop1), .tx_eop(tx_eop1), .tx_ready(tx_ready),
        .seq_num(seq_num1), .drop_cnt(drop_cnt1), .drop_clr(drop_clr)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_beat = 0;
        m_pkts = 32'd0;
        m_drop = 16'd0;
    endtask

    task automatic check_set(input string who, input logic [31:0] base,
                             input logic v, input logic [63:0] d, input logic s,
                             input logic e, input logic r, input logic [31:0] sq,
                             input logic [15:0] dc);
        logic        ev;
        logic [63:0] ed;
        logic [31:0] eseq;
        eseq = base + m_pkts;
        ev   = (mq.size() > 0);
        chk({who, "_tx_valid"}, v, ev);
        chk({who, "_ord_ready"}, r, mq.size() != DEPTH);
        chk({who, "_seq_num"}, sq, eseq);
        chk({who, "_drop_cnt"}, dc, m_drop);
        if (ev) begin
            case (m_beat)
                0:       ed = {eseq, 16'h0000, 16'd16};
                1:       ed = mq[0][127:64];
                default: ed = mq[0][63:0];
            endcase
            chk({who, "_tx_data"}, d, ed);
            chk({who, "_tx_sop"}, s, m_beat == 0);
            chk({who, "_tx_eop"}, e, m_beat == 2);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model across the edge.
    task automatic step(input logic v, input logic [127:0] d, input logic r, input logic c);
        logic full;
        logic ev;
        @(negedge clk);
        ord_valid = v;
        ord_data  = d;
        tx_ready  = r;
        drop_clr  = c;
        #1;
        check_set("d0", INIT0, tx_valid0, tx_data0, tx_sop0, tx_eop0, ord_ready0, seq_num0, drop_cnt0);
        check_set("d1", INIT1, tx_valid1, tx_data1, tx_sop1, tx_eop1, ord_ready1, seq_num1, drop_cnt1);
        if (tx_valid0 && r) hs_cnt++;
        full = (mq.size() == DEPTH);
        ev   = (mq.size() > 0);
        if (ev && r) begin
            if (m_beat == 2) begin
                void'(mq.pop_front());
                m_pkts = m_pkts + 32'd1;
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (v && !full) mq.push_back(d);
        if (c) m_drop = (v && full) ? 16'd1 : 16'd0;
        else if (v && full && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] zero;
        zero      = '0;
        reset_n   = 1'b0;
        ord_valid = 1'b0;
        ord_data  = '0;
        tx_ready  = 1'b0;
        drop_clr  = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx_valid", tx_valid0, 1'b0);
        chk("rst_tx_sop", tx_sop0, 1'b0);
        chk("rst_tx_eop", tx_eop0, 1'b0);
        chk("rst_tx_data", tx_data0, 64'h0);
        chk("rst_ord_ready", ord_ready0, 1'b1);
        chk("rst_seq0", seq_num0, INIT0);
        chk("rst_seq1", seq_num1, INIT1);
        chk("rst_drop", drop_cnt0, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single order with tx_ready high
        step(1'b1, 128'h0123456789ABCDEF_0011223344ABCDEF, 1'b1, 1'b0);
        repeat (5) step(1'b0, zero, 1'b1, 1'b0);
        chk("single_seq0", seq_num0, 32'd1);
        chk("single_seq1", seq_num1, 32'd0);

        // Backpressure during a packet
        step(1'b1, rnd128(), 1'b0, 1'b0);
        hs_cnt = 0;
        step(1'b0, zero, 1'b1, 1'b0);
        step(1'b0, zero, 1'b0, 1'b0);
        step(1'b0, zero, 1'b0, 1'b0);
        step(1'b0, zero, 1'b1, 1'b0);
        step(1'b0, zero, 1'b0, 1'b0);
        step(1'b0, zero, 1'b1, 1'b0);
        step(1'b0, zero, 1'b1, 1'b0);
        chk("bp_handshakes", hs_cnt, 3);

        // Overflow: six offers into a four-entry FIFO with the output stalled
        repeat (6) step(1'b1, rnd128(), 1'b0, 1'b0);
        step(1'b0, zero, 1'b0, 1'b0);
        chk("ovf_ready", ord_ready0, 1'b0);
        chk("ovf_drop", drop_cnt0, 16'd2);
        hs_cnt = 0;
        repeat (14) step(1'b0, zero, 1'b1, 1'b0);
        chk("ovf_drain_hs", hs_cnt, 12);

        // Drop counter saturation and clear behaviour
        repeat (65536 + 5 + 4) step(1'b1, rnd128(), 1'b0, 1'b0);
        step(1'b0, zero, 1'b0, 1'b0);
        chk("sat_drop", drop_cnt0, 16'hFFFF);
        step(1'b1, rnd128(), 1'b0, 1'b1);
        step(1'b0, zero, 1'b0, 1'b0);
        chk("clr_with_drop", drop_cnt0, 16'd1);
        step(1'b0, zero, 1'b0, 1'b1);
        step(1'b0, zero, 1'b0, 1'b0);
        chk("clr_alone", drop_cnt0, 16'd0);
        repeat (14) step(1'b0, zero, 1'b1, 1'b0);

        // Randomized traffic
        repeat (400) begin
            step(($urandom_range(0, 2) != 0), rnd128(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
        end
        repeat (16) step(1'b0, zero, 1'b1, 1'b0);

        // Reset while the low beat is pending
        step(1'b1, rnd128(), 1'b0, 1'b0);
        step(1'b1, rnd128(), 1'b1, 1'b0);
        step(1'b0, zero, 1'b1, 1'b0);
        step(1'b0, zero, 1'b0, 1'b0);
        chk("mid_eop_before_rst", tx_eop0, 1'b1);
        @(negedge clk);
        reset_n   = 1'b0;
        ord_valid = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid0, 1'b0);
        chk("mid_rst_eop", tx_eop0, 1'b0);
        chk("mid_rst_ready", ord_ready0, 1'b1);
        chk("mid_rst_seq0", seq_num0, INIT0);
        chk("mid_rst_seq1", seq_num1, INIT1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, zero, 1'b1, 1'b0);
        step(1'b1, 128'hDEADBEEF_00000001_CAFEF00D_00000002, 1'b1, 1'b0);
        step(1'b0, zero, 1'b1, 1'b0);
        chk("post_rst_sop", tx_sop0, 1'b1);
        chk("post_rst_hdr", tx_data0, {INIT0, 16'h0000, 16'd16});
        repeat (4) step(1'b0, zero, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
